// File: rtl/board_io_pkg.sv
// Shared timing constants for the board I/O blocks (switches, LEDs).
// Every input conditioner derives its debounce window from here.
package board_io_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned DEBOUNCE_MS = 10;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS);

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, debounce counter, accepted level,
// single-cycle rise/fall pulses and a toggle that flips on every rise.
module debounce_channel
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = board_io_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic sw_level,
    output logic sw_rise,
    output logic sw_fall,
    output logic sw_toggle
);

    localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_toggle;

    logic w_mismatch;
    logic w_cnt_done;

    assign w_mismatch = (r_sync != r_level);
    assign w_cnt_done = (r_cnt == CNT_MAX);

    // Synchronizer flops kept back-to-back so both sit in the same slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= sw;
            r_sync <= r_meta;
        end
    end

    // Any agreement between sync and level clears the count, so a bounce
    // restarts the window rather than pausing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_toggle <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_cnt_done) begin
                r_cnt   <= '0;
                r_level <= r_sync;
                r_rise  <= r_sync;
                r_fall  <= ~r_sync;
                if (r_sync) begin
                    r_toggle <= ~r_toggle;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sw_level  = r_level;
    assign sw_rise   = r_rise;
    assign sw_fall   = r_fall;
    assign sw_toggle = r_toggle;

endmodule

// File: rtl/switch_reader.sv
// Conditioner for the board slide switches/buttons: N_CH independent
// debounce channels producing clean levels, edge pulses and toggles.
module switch_reader
    import board_io_pkg::*;
#(
    parameter int unsigned N_CH            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = board_io_pkg::DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] sw_level,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall,
    output logic [N_CH-1:0] sw_toggle
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .sw        (sw[g]),
            .sw_level  (sw_level[g]),
            .sw_rise   (sw_rise[g]),
            .sw_fall   (sw_fall[g]),
            .sw_toggle (sw_toggle[g])
        );
    end

endmodule

// File: tb/tb_switch_reader.sv
// Directed bench for switch_reader with a short debounce window (8 cycles).
module tb_switch_reader;

    localparam int unsigned N_CH = 2;
    localparam int unsigned DC   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] sw_level;
    logic [N_CH-1:0] sw_rise;
    logic [N_CH-1:0] sw_fall;
    logic [N_CH-1:0] sw_toggle;

    int checks   = 0;
    int failures = 0;

    switch_reader #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .sw_level  (sw_level),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_toggle (sw_toggle)
    );

    always #5 clk = ~clk;

    // Each record: inputs driven before an edge, outputs expected just after it.
    typedef struct {
        logic       rst;
        logic [1:0] sw;
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] tog;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] s, input logic [1:0] l,
                       input logic [1:0] ri, input logic [1:0] f,
                       input logic [1:0] t, input int n);
        vec_t v;
        v.rst = r; v.sw = s; v.lvl = l; v.rise = ri; v.fall = f; v.tog = t;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int pulse_edge;
        int early;
        int falls;

        rst = 1'b1;
        sw  = '0;

        // Reset, including pads toggling while rst is held.
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        for (int i = 0; i < 4; i++)
            add(1, (i % 2 == 0) ? 2'b11 : 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        // Clean press on ch0: level lands on the 10th edge after the step.
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 9);
        add(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 1);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 3);
        // 5-cycle glitch on ch1 is rejected.
        add(0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 5);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 12);
        // Release ch0: fall pulse, toggle holds.
        add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 9);
        add(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1);
        add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2);
        // Second press on ch0 toggles back to 0.
        add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 9);
        add(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1);
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2);
        // Simultaneous ch0 release and ch1 press stay independent.
        add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 9);
        add(0, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 1);
        add(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            sw  = vecs[i].sw;
            tick();
            chk($sformatf("vec%0d_level", i),  sw_level,  vecs[i].lvl);
            chk($sformatf("vec%0d_rise", i),   sw_rise,   vecs[i].rise);
            chk($sformatf("vec%0d_fall", i),   sw_fall,   vecs[i].fall);
            chk($sformatf("vec%0d_toggle", i), sw_toggle, vecs[i].tog);
        end

        // Bounce 1,0,1,0,1 on ch0 then hold: one rise, 10 edges after the last transition.
        rst = 1'b1; sw = 2'b00; tick();
        rst = 1'b0; tick();
        pulses = 0; pulse_edge = -1; falls = 0;
        for (int e = 1; e <= 30; e++) begin
            sw[0] = (e <= 5) ? ((e % 2) == 1) : 1'b1;
            tick();
            if (sw_rise[0]) begin
                pulses++;
                pulse_edge = e;
            end
            if (sw_fall != 2'b00) falls++;
            if (e == 13) chk("bounce_level_before", sw_level, 2'b00);
        end
        chk_int("bounce_rise_count", pulses, 1);
        chk_int("bounce_rise_edge", pulse_edge, 14);
        chk_int("bounce_fall_count", falls, 0);
        chk("bounce_level_after", sw_level, 2'b01);
        chk("bounce_toggle", sw_toggle, 2'b01);

        // Reset one cycle mid-count on ch1: the partial count is discarded.
        rst = 1'b1; sw = 2'b00; tick();
        rst = 1'b0;
        early = 0;
        for (int e = 1; e <= 18; e++) begin
            sw  = 2'b10;
            rst = (e == 5);
            tick();
            if (e < 15 && (sw_level[1] || sw_rise[1])) early++;
            if (e == 5)  chk("rstmid_reset_edge", sw_level | sw_rise | sw_fall | sw_toggle, 2'b00);
            if (e == 10) chk("rstmid_orig_edge_rise", sw_rise, 2'b00);
            if (e == 15) begin
                chk("rstmid_level", sw_level, 2'b10);
                chk("rstmid_rise", sw_rise, 2'b10);
                chk("rstmid_toggle", sw_toggle, 2'b10);
            end
            if (e == 16) chk("rstmid_rise_drop", sw_rise, 2'b00);
        end
        chk_int("rstmid_early_events", early, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_reader.md
Name: switch_reader

Overview:
Input-side conditioner for the board slide switches and buttons. It takes raw asynchronous pad levels and produces clean, clock-domain levels and single-cycle event pulses for downstream LED and control logic. Each channel has a 2-flop synchronizer, a debounce counter and edge detection, plus a per-channel toggle state that flips on each debounced rising edge. It sits directly behind the top-level switch pins, and everything that reacts to switches reads its outputs instead of the raw pins.

Parameters:
N_CH, 2, number of independent switch channels (>=1).
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a level is accepted (10 ms at 100 MHz); must be >=2.
CNT_W, $clog2(DEBOUNCE_CYCLES), localparam, debounce counter width; not overridable.

Ports:
clk  input  1  system clock, 100 MHz board oscillator
rst  input  1  synchronous reset, active-high
sw  input  N_CH  raw switch/button levels, asynchronous to clk
sw_level  output  N_CH  debounced, synchronized level per channel
sw_rise  output  N_CH  1-cycle pulse when sw_level goes 0->1
sw_fall  output  N_CH  1-cycle pulse when sw_level goes 1->0
sw_toggle  output  N_CH  per-channel state, inverts on every sw_rise

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. All state updates occur on the rising clk edge.
- Reset: sync flops, counters, sw_level, sw_rise, sw_fall and sw_toggle are all 0 at the edge where rst=1.
- rst asserted mid-count discards any partial count. rst has priority over every other update.
- Channels are fully independent. There is no cross-channel interaction.
- Synchronizer: sw_meta <= sw; sw_sync <= sw_meta. No logic is placed between the two flops.
- Debounce, per channel, each edge:
  - sw_sync == sw_level: cnt <= 0, no event.
  - sw_sync != sw_level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sw_sync != sw_level and cnt == DEBOUNCE_CYCLES-1: sw_level <= sw_sync, cnt <= 0, and the matching pulse is asserted.
- Latency: a clean step on sw that is held long enough appears on sw_level exactly DEBOUNCE_CYCLES+2 edges after the first edge that samples the new value.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES cycles at sw_sync resets cnt to 0 when it clears. sw_level does not change and no pulse is produced.
- A bounce in the middle of the window restarts the count from 0. The count is not paused.
- Pulses:
  - sw_rise and sw_fall are registered and high for exactly the one cycle following the sw_level update edge. They are aligned with the first cycle of the new sw_level.
  - sw_rise and sw_fall are never both high on the same channel.
  - The minimum spacing between two pulses on one channel is DEBOUNCE_CYCLES cycles.
- Toggle: sw_toggle flips at the same edge that raises sw_rise, so the new value is visible together with the pulse. sw_fall does not affect sw_toggle.
- Power-up with a switch held high: after rst deasserts, sw_level rises after DEBOUNCE_CYCLES+2 edges. sw_rise fires once and sw_toggle becomes 1. This is intended behaviour; consumers that need absolute position use sw_level.
- Counter arithmetic is unsigned, CNT_W bits. It never wraps, because it is capped at DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package board_io_pkg:
  - CLK_HZ = 100_000_000.
  - DEBOUNCE_MS = 10.
  - The derived DEBOUNCE_CYCLES constant, so the LED and other input blocks share one timing source.
- One natural sub-module, debounce_channel: 1-bit synchronizer, counter, level, pulses and toggle. switch_reader instantiates N_CH of these in a generate loop.

Test Plan (sim with DEBOUNCE_CYCLES=8, N_CH=2):
- Reset: hold rst 3 cycles with sw=2'b00, then release -> all outputs 0. Also hold rst while sw toggles every cycle -> outputs stay 0.
- Clean step: sw[0] 0->1 at edge E0 and held -> sw_level[0]=1 first observed after edge E10; sw_rise[0]=1 for exactly that one cycle; sw_toggle[0]=1; channel 1 unchanged.
- Glitch: sw[1] high for 5 cycles, then low -> sw_level[1], sw_rise[1] and sw_fall[1] stay 0 throughout, and cnt returns to 0.
- Bounce then settle: sw[0] toggles 1,0,1,0,1 over 5 cycles, then holds 1 -> exactly one sw_rise[0] pulse, 10 edges after the final transition.
- Release and toggle: after settling high, drive sw[0] low and held -> one sw_fall[0] pulse and sw_toggle[0] stays 1. A second press gives sw_toggle[0]=0.
- Reset mid-count: sw[1] 0->1, assert rst 4 cycles later for 1 cycle -> no pulse at the original E10. sw_level[1]=1 appears 10 edges after the first post-reset edge.
